payload_parser: RTL
===================

# payload_parser

Receive-side counterpart of the order-payload transmitter. Accepts the 3-beat, 256-bit AXI-Stream order message (80 bytes plus 16 zero pad bytes), reassembles it, and verifies framing, header constants and the additive checksum. It then presents the decoded fields with a one-cycle `out_valid` strobe. It sits between the stream demux and the order-book/ack logic.

## Interface
Parameters:
- `MSG_LEN`, default 77: expected `msg_length` field value.
- `MSG_TYPE`, default 101: expected `MessageType` value.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  synchronous, active-low reset.
- `s_tdata`  in  256  stream data; byte n of message = `s_tdata[8k+7:8k]` of beat n/32, where k = n mod 32.
- `s_tvalid`  in  1  beat valid.
- `s_tready`  out  1  beat accept.
- `s_tlast`  in  1  last beat of frame.
- `s_tkeep`  in  32  byte enables; must be all ones.
- `out_valid`  out  1  one-cycle strobe: message received and fully checked.
- `out_msg`  out  632  bytes 0..78 of the message, byte 0 at [7:0].
- `msg_seq_num`  out  32  bytes 2..5.
- `exec_type`  out  8  byte 17.
- `ord_id`  out  32  bytes 27..30.
- `sym`  out  160  bytes 40..59.
- `price`  out  32  bytes 60..63.
- `qty`  out  16  bytes 64..65.
- `side`  out  8  byte 71.
- `err_chk`  out  1  checksum mismatch, valid with `out_valid`.
- `err_hdr`  out  1  `msg_length`≠MSG_LEN or `MessageType`≠MSG_TYPE, valid with `out_valid`.
- `err_frame`  out  1  one-cycle strobe when a frame is discarded.
- `cnt_ok`  out  16  count of messages with no error; wraps.
- `cnt_err`  out  16  count of messages with `err_chk`/`err_hdr`, plus discarded frames; wraps.

## Operation
- Multi-byte fields are little-endian at fixed byte offsets:
  - 0 len, 2 seq, 6 epoch_s, 10 ms, 12 type, 13 hdr_fcm, 15 session, 17 exec_type, 18 cm_id, 20 fcm_id.
  - 22..26 order_no4..0, 27 ord_id, 31..38 user_define7..0, 39 symbol_type, 40 sym, 60 price, 64 qty.
  - 66 investor_acno, 70 inv_flag, 71 side, 72 OrdType, 73 TIF, 74 PosEff, 75 order_source, 76..78 info_source2..0, 79 checksum, 80..95 pad (ignored).
- Checksum: low 8 bits of the sum of bytes 0..78, compared to byte 79.
  - Accumulate per beat in a ≥16-bit register: beat0 sums 32 bytes, beat1 sums 32 bytes, beat2 sums bytes 0..14.
  - Compare only `[7:0]`.
- FSM states: B0, B1, B2, CHECK, DRAIN.
  - B0/B1/B2: `s_tready`=1. Each accepted beat is stored and summed, then advance one state.
  - If `s_tlast`=1 on B0 or B1, or `s_tkeep`≠all ones: pulse `err_frame`, increment `cnt_err`, go to B0.
  - B2 accepted with `s_tlast`=1 → CHECK. B2 accepted with `s_tlast`=0 → DRAIN.
  - DRAIN: `s_tready`=1, discard beats until a beat with `s_tlast`=1, then pulse `err_frame`, increment `cnt_err`, go to B0.
  - CHECK: `s_tready`=0 for exactly one cycle. Register all outputs and error flags, update one counter, assert `out_valid` next cycle, go to B0.
- Errored messages still pulse `out_valid` with the flag set. The consumer drops them.
- Output field registers hold their value until the next CHECK.

## Timing
- Reset values: `s_tready`=0 during reset and 1 from the first cycle after reset; all other outputs 0; state B0; accumulators 0.
- Latency: `out_valid` is high in the 2nd cycle after the edge that accepts beat 2.
- A beat is accepted only on a cycle with `s_tvalid`&`s_tready`. Bubbles between beats are allowed.
- Upstream must leave ≥1 idle cycle between messages. A `s_tvalid` during CHECK is not accepted and is held by protocol.
- Reset mid-message: the partial message is discarded, no `out_valid`, counters cleared.
- Counters wrap 0xFFFF → 0x0000.
- `err_frame` and `out_valid` are never high in the same cycle.

## Structure
- `payload_pkg`:
  - Byte-offset localparams per field; `PAYLOAD_BYTES`=80; `CHK_OFFSET`=79.
  - Header constants: 77, 101, fcm 237, PositionEffect 79, info_source 57.
  - A packed struct of decoded fields. Shared with the transmitter.
- Sub-module `byte_sum32`: combinational 32-byte adder tree with a per-byte mask. One instance, reused each beat.

## Test plan
- Message with all fields 0 except the constants, price=0x64, qty=5, checksum byte 0xEF → `out_valid`, `price`=0x64, `qty`=5, no errors, `cnt_ok`=1.
- Same message with checksum byte 0xEE → `err_chk`=1, `err_hdr`=0, `cnt_err`=1.
- `msg_length`=78 with correct checksum 0xF0 → `err_hdr`=1, `err_chk`=0.
- `s_tlast` on beat 1 → `err_frame` pulse, no `out_valid`. The next good message is accepted normally.
- Beat 2 without `s_tlast`, then a 4th beat with `s_tlast` → DRAIN, one `err_frame`, no `out_valid`.
- `resetn` low for 1 cycle after beat 1 → no `out_valid`. A full message after reset decodes correctly with `cnt_ok`=1.

Source files
------------

// File: rtl/payload_pkg.sv
// Shared order-payload layout: byte offsets, header constants and decoded field view.
package payload_pkg;

  localparam int PAYLOAD_BYTES = 80;
  localparam int CHK_OFFSET    = 79;
  localparam int OUT_BYTES     = 79;

  // Little-endian field offsets within the 80-byte message
  localparam int OFF_LEN      = 0;
  localparam int OFF_SEQ      = 2;
  localparam int OFF_EPOCH_S  = 6;
  localparam int OFF_MS       = 10;
  localparam int OFF_TYPE     = 12;
  localparam int OFF_HDR_FCM  = 13;
  localparam int OFF_SESSION  = 15;
  localparam int OFF_EXEC     = 17;
  localparam int OFF_CM_ID    = 18;
  localparam int OFF_FCM_ID   = 20;
  localparam int OFF_ORDER_NO = 22;
  localparam int OFF_ORD_ID   = 27;
  localparam int OFF_USER_DEF = 31;
  localparam int OFF_SYM_TYPE = 39;
  localparam int OFF_SYM      = 40;
  localparam int OFF_PRICE    = 60;
  localparam int OFF_QTY      = 64;
  localparam int OFF_INV_ACNO = 66;
  localparam int OFF_INV_FLAG = 70;
  localparam int OFF_SIDE     = 71;
  localparam int OFF_ORD_TYPE = 72;
  localparam int OFF_TIF      = 73;
  localparam int OFF_POS_EFF  = 74;
  localparam int OFF_ORD_SRC  = 75;
  localparam int OFF_INFO_SRC = 76;

  // Header constants stamped by the transmitter
  localparam logic [15:0] HDR_MSG_LEN  = 16'd77;
  localparam logic [7:0]  HDR_MSG_TYPE = 8'd101;
  localparam logic [7:0]  HDR_FCM      = 8'd237;
  localparam logic [7:0]  HDR_POS_EFF  = 8'd79;
  localparam logic [7:0]  HDR_INFO_SRC = 8'd57;

  typedef struct packed {
    logic [31:0]  seq;
    logic [7:0]   exec_type;
    logic [31:0]  ord_id;
    logic [159:0] sym;
    logic [31:0]  price;
    logic [15:0]  qty;
    logic [7:0]   side;
  } order_fields_t;

  // Pull the fields the order book needs out of bytes 0..78
  function automatic order_fields_t decode_fields(input logic [8*OUT_BYTES-1:0] m);
    order_fields_t f;
    f.seq       = m[8*OFF_SEQ    +: 32];
    f.exec_type = m[8*OFF_EXEC   +: 8];
    f.ord_id    = m[8*OFF_ORD_ID +: 32];
    f.sym       = m[8*OFF_SYM    +: 160];
    f.price     = m[8*OFF_PRICE  +: 32];
    f.qty       = m[8*OFF_QTY    +: 16];
    f.side      = m[8*OFF_SIDE   +: 8];
    return f;
  endfunction

endpackage

// File: rtl/payload_parser_byte_sum32.sv
// Combinational sum of up to 32 bytes of one beat, masked per byte.
module byte_sum32 (
  input  logic [255:0] data,
  input  logic [31:0]  mask,
  output logic [12:0]  sum
);

  // 32 x 255 fits in 13 bits, so no carry is lost
  always_comb begin
    sum = '0;
    for (int i = 0; i < 32; i++)
      if (mask[i]) sum = sum + 13'(data[8*i +: 8]);
  end

endmodule

// File: rtl/payload_parser.sv
// Reassembles the 3-beat order message, checks framing/header/checksum, decodes fields.
module payload_parser
  import payload_pkg::*;
#(
  parameter int MSG_LEN  = 77,
  parameter int MSG_TYPE = 101
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [255:0]  s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  input  logic [31:0]   s_tkeep,
  output logic          out_valid,
  output logic [631:0]  out_msg,
  output logic [31:0]   msg_seq_num,
  output logic [7:0]    exec_type,
  output logic [31:0]   ord_id,
  output logic [159:0]  sym,
  output logic [31:0]   price,
  output logic [15:0]   qty,
  output logic [7:0]    side,
  output logic          err_chk,
  output logic          err_hdr,
  output logic          err_frame,
  output logic [15:0]   cnt_ok,
  output logic [15:0]   cnt_err
);

  localparam logic [2:0] B0    = 3'd0;
  localparam logic [2:0] B1    = 3'd1;
  localparam logic [2:0] B2    = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [8*PAYLOAD_BYTES-1:0]   data_q, data_d;
  logic [15:0]                  sum_q, sum_d;
  logic [631:0]                 out_msg_q, out_msg_d;
  logic                         out_valid_q, out_valid_d;
  logic                         err_chk_q, err_chk_d;
  logic                         err_hdr_q, err_hdr_d;
  logic                         err_frame_q, err_frame_d;
  logic [15:0]                  cnt_ok_q, cnt_ok_d;
  logic [15:0]                  cnt_err_q, cnt_err_d;

  logic        accept, keep_ok, bad_chk, bad_hdr;
  logic [31:0] beat_mask;
  logic [12:0] beat_sum;
  order_fields_t fields;

  // Beat 2 only carries message bytes 64..78 into the checksum
  assign beat_mask = (state_q == B2) ? 32'h0000_7FFF : 32'hFFFF_FFFF;

  byte_sum32 u_sum (
    .data (s_tdata),
    .mask (beat_mask),
    .sum  (beat_sum)
  );

  assign s_tready = resetn && (state_q != CHECK);
  assign accept   = s_tvalid && s_tready;
  assign keep_ok  = &s_tkeep;
  assign bad_chk  = sum_q[7:0] != data_q[8*CHK_OFFSET +: 8];
  assign bad_hdr  = (data_q[8*OFF_LEN +: 16] != 16'(MSG_LEN)) ||
                    (data_q[8*OFF_TYPE +: 8] != 8'(MSG_TYPE));

  // Frame FSM: store/sum beats, drop bad frames, latch results on CHECK
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sum_d       = sum_q;
    out_msg_d   = out_msg_q;
    out_valid_d = 1'b0;
    err_chk_d   = err_chk_q;
    err_hdr_d   = err_hdr_q;
    err_frame_d = 1'b0;
    cnt_ok_d    = cnt_ok_q;
    cnt_err_d   = cnt_err_q;
    case (state_q)
      B0, B1: if (accept) begin
        if (!keep_ok || s_tlast) begin
          err_frame_d = 1'b1;
          cnt_err_d   = cnt_err_q + 16'd1;
          state_d     = B0;
        end else if (state_q == B0) begin
          data_d[255:0] = s_tdata;
          sum_d         = 16'(beat_sum);
          state_d       = B1;
        end else begin
          data_d[511:256] = s_tdata;
          sum_d           = sum_q + 16'(beat_sum);
          state_d         = B2;
        end
      end
      B2: if (accept) begin
        if (!keep_ok) begin
          err_frame_d = 1'b1;
          cnt_err_d   = cnt_err_q + 16'd1;
          state_d     = B0;
        end else begin
          data_d[639:512] = s_tdata[127:0];
          sum_d           = sum_q + 16'(beat_sum);
          state_d         = s_tlast ? CHECK : DRAIN;
        end
      end
      CHECK: begin
        out_msg_d   = data_q[631:0];
        err_chk_d   = bad_chk;
        err_hdr_d   = bad_hdr;
        out_valid_d = 1'b1;
        if (bad_chk || bad_hdr) cnt_err_d = cnt_err_q + 16'd1;
        else                    cnt_ok_d  = cnt_ok_q + 16'd1;
        state_d = B0;
      end
      DRAIN: if (accept && s_tlast) begin
        err_frame_d = 1'b1;
        cnt_err_d   = cnt_err_q + 16'd1;
        state_d     = B0;
      end
      default: state_d = B0;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= B0;
      data_q      <= '0;
      sum_q       <= '0;
      out_msg_q   <= '0;
      out_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_hdr_q   <= 1'b0;
      err_frame_q <= 1'b0;
      cnt_ok_q    <= '0;
      cnt_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      out_msg_q   <= out_msg_d;
      out_valid_q <= out_valid_d;
      err_chk_q   <= err_chk_d;
      err_hdr_q   <= err_hdr_d;
      err_frame_q <= err_frame_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign fields      = decode_fields(out_msg_q);
  assign out_valid   = out_valid_q;
  assign out_msg     = out_msg_q;
  assign msg_seq_num = fields.seq;
  assign exec_type   = fields.exec_type;
  assign ord_id      = fields.ord_id;
  assign sym         = fields.sym;
  assign price       = fields.price;
  assign qty         = fields.qty;
  assign side        = fields.side;
  assign err_chk     = err_chk_q;
  assign err_hdr     = err_hdr_q;
  assign err_frame   = err_frame_q;
  assign cnt_ok      = cnt_ok_q;
  assign cnt_err     = cnt_err_q;

endmodule
